// File: rtl/echo_delay_ctrl.sv
// Echo sequencer for a single-clock dual-port delay-line RAM: each input sample
// is mixed with a gain-scaled copy of the output from `delay` samples earlier and written back.
module echo_delay_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         enable,
  input  logic        [ADDR_WIDTH-1:0] delay,
  input  logic        [3:0]            gain,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         busy,
  output logic                         overrun,
  output logic                         ram_wren,
  output logic        [ADDR_WIDTH-1:0] ram_wraddress,
  output logic        [DATA_WIDTH-1:0] ram_data,
  output logic                         ram_rden,
  output logic        [ADDR_WIDTH-1:0] ram_rdaddress,
  input  logic signed [DATA_WIDTH-1:0] ram_q
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDR_WIDTH;

  typedef enum logic [2:0] {IDLE, RD, WAIT, MIX, WR} state_e;

  state_e state_q, state_d;

  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        fill_q, fill_d;
  logic [AW-1:0]        delay_q, delay_d;
  logic signed [DW-1:0] in_q, in_d;
  logic signed [DW-1:0] dly_q, dly_d;
  logic                 en_q, en_d;
  logic [3:0]           gain_q, gain_d;

  logic                 out_valid_q, out_valid_d;
  logic signed [DW-1:0] out_data_q, out_data_d;
  logic                 busy_q, busy_d;
  logic                 overrun_q, overrun_d;
  logic                 ram_wren_q, ram_wren_d;
  logic [AW-1:0]        ram_wraddress_q, ram_wraddress_d;
  logic [DW-1:0]        ram_data_q, ram_data_d;
  logic                 ram_rden_q, ram_rden_d;
  logic [AW-1:0]        ram_rdaddress_q, ram_rdaddress_d;

  logic                 use_echo;
  logic signed [DW+4:0] prod;
  logic signed [DW+4:0] echo;
  logic signed [DW+5:0] sum;
  logic signed [DW-1:0] mix;

  // Echo is masked during warm-up: RAM cells older than fill_cnt were never written.
  always_comb begin
    use_echo = en_q && (delay_q != '0) && (fill_q >= delay_q);
    prod = $signed({{5{dly_q[DW-1]}}, dly_q}) * $signed({{(DW+1){1'b0}}, gain_q});
    if (use_echo) echo = prod >>> 4;
    else          echo = '0;
    sum = $signed({{6{in_q[DW-1]}}, in_q}) + $signed({echo[DW+4], echo});
    if ((sum[DW+5:DW-1] == '0) || (sum[DW+5:DW-1] == '1)) mix = sum[DW-1:0];
    else if (sum[DW+5])                                   mix = {1'b1, {(DW-1){1'b0}}};
    else                                                  mix = {1'b0, {(DW-1){1'b1}}};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = RD;
      RD:      state_d = WAIT;
      WAIT:    state_d = MIX;
      MIX:     state_d = WR;
      WR:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d        = wr_ptr_q;
    fill_d          = fill_q;
    delay_d         = delay_q;
    in_d            = in_q;
    dly_d           = dly_q;
    en_d            = en_q;
    gain_d          = gain_q;
    out_data_d      = out_data_q;
    busy_d          = busy_q;
    ram_wraddress_d = ram_wraddress_q;
    ram_data_d      = ram_data_q;
    ram_rdaddress_d = ram_rdaddress_q;
    out_valid_d     = 1'b0;
    ram_wren_d      = 1'b0;
    ram_rden_d      = 1'b0;
    overrun_d       = in_valid && (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          in_d            = in_data;
          en_d            = enable;
          delay_d         = delay;
          gain_d          = gain;
          ram_rden_d      = 1'b1;
          ram_rdaddress_d = wr_ptr_q - delay;
          busy_d          = 1'b1;
        end
      end
      WAIT: dly_d = ram_q;
      MIX: begin
        ram_wren_d      = 1'b1;
        ram_wraddress_d = wr_ptr_q;
        ram_data_d      = mix;
        out_valid_d     = 1'b1;
        out_data_d      = mix;
      end
      WR: begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        if (fill_q != '1) fill_d = fill_q + AW'(1);
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q        <= '0;
      fill_q          <= '0;
      delay_q         <= '0;
      in_q            <= '0;
      dly_q           <= '0;
      en_q            <= 1'b0;
      gain_q          <= '0;
      out_valid_q     <= 1'b0;
      out_data_q      <= '0;
      busy_q          <= 1'b0;
      overrun_q       <= 1'b0;
      ram_wren_q      <= 1'b0;
      ram_wraddress_q <= '0;
      ram_data_q      <= '0;
      ram_rden_q      <= 1'b0;
      ram_rdaddress_q <= '0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      fill_q          <= fill_d;
      delay_q         <= delay_d;
      in_q            <= in_d;
      dly_q           <= dly_d;
      en_q            <= en_d;
      gain_q          <= gain_d;
      out_valid_q     <= out_valid_d;
      out_data_q      <= out_data_d;
      busy_q          <= busy_d;
      overrun_q       <= overrun_d;
      ram_wren_q      <= ram_wren_d;
      ram_wraddress_q <= ram_wraddress_d;
      ram_data_q      <= ram_data_d;
      ram_rden_q      <= ram_rden_d;
      ram_rdaddress_q <= ram_rdaddress_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign busy          = busy_q;
  assign overrun       = overrun_q;
  assign ram_wren      = ram_wren_q;
  assign ram_wraddress = ram_wraddress_q;
  assign ram_data      = ram_data_q;
  assign ram_rden      = ram_rden_q;
  assign ram_rdaddress = ram_rdaddress_q;

endmodule

// File: tb/tb_echo_delay_ctrl.sv
// Directed bench for echo_delay_ctrl: vector table on the default-size instance,
// hand-written sequences for overrun, mid-write reset and a 16-deep wrap case.
module tb_echo_delay_ctrl;

  logic               clock;
  logic               reset;
  logic               in_valid, enable;
  logic signed [15:0] in_data;
  logic [10:0]        delay;
  logic [3:0]         gain;
  logic               out_valid, busy, overrun, ram_wren, ram_rden;
  logic signed [15:0] out_data;
  logic [10:0]        ram_wraddress, ram_rdaddress;
  logic [15:0]        ram_data;
  logic signed [15:0] ram_q;

  logic               in_valid4, enable4;
  logic signed [15:0] in_data4;
  logic [3:0]         delay4;
  logic [3:0]         gain4;
  logic               out_valid4, busy4, overrun4, ram_wren4, ram_rden4;
  logic signed [15:0] out_data4;
  logic [3:0]         ram_wraddress4, ram_rdaddress4;
  logic [15:0]        ram_data4;
  logic signed [15:0] ram_q4;

  int vectors = 0;
  int miscompares = 0;

  echo_delay_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(11)) u_dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .enable(enable), .delay(delay), .gain(gain), .out_valid(out_valid),
    .out_data(out_data), .busy(busy), .overrun(overrun), .ram_wren(ram_wren),
    .ram_wraddress(ram_wraddress), .ram_data(ram_data), .ram_rden(ram_rden),
    .ram_rdaddress(ram_rdaddress), .ram_q(ram_q)
  );

  echo_delay_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) u_dut4 (
    .clock(clock), .reset(reset), .in_valid(in_valid4), .in_data(in_data4),
    .enable(enable4), .delay(delay4), .gain(gain4), .out_valid(out_valid4),
    .out_data(out_data4), .busy(busy4), .overrun(overrun4), .ram_wren(ram_wren4),
    .ram_wraddress(ram_wraddress4), .ram_data(ram_data4), .ram_rden(ram_rden4),
    .ram_rdaddress(ram_rdaddress4), .ram_q(ram_q4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Dual-port RAM models, read data registered one clock after rden.
  logic signed [15:0] mem  [0:2047];
  logic signed [15:0] mem4 [0:15];
  bit init_done = 1'b0;
  int wren_cnt = 0;

  always @(posedge clock) begin
    if (!init_done) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 16'sh7FFF;
      for (int i = 0; i < 16; i++) mem4[i] <= 16'sh7FFF;
      init_done <= 1'b1;
    end else begin
      if (ram_wren) mem[ram_wraddress] <= ram_data;
      if (ram_wren4) mem4[ram_wraddress4] <= ram_data4;
    end
    if (ram_rden) ram_q <= mem[ram_rdaddress];
    if (ram_rden4) ram_q4 <= mem4[ram_rdaddress4];
    if (ram_wren) wren_cnt <= wren_cnt + 1;
  end

  typedef struct {
    int din;
    bit en;
    int dly;
    int g;
    int exp;
    bit rst;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(int din, bit en, int dly, int g, int exp, bit rst);
    vec_t v;
    v.din = din; v.en = en; v.dly = dly; v.g = g; v.exp = exp; v.rst = rst;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // One sample through the main instance; checks strobe/busy timing, returns output and write address.
  task automatic do_sample(input int din, input bit en, input int dly, input int g,
                           output int got, output int waddr);
    int vpat, bpat;
    @(negedge clock);
    in_data = 16'(din); enable = en; delay = 11'(dly); gain = 4'(g);
    in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    vpat = 0; bpat = 0; got = -99999; waddr = -1;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clock);
      vpat |= int'(out_valid) << c;
      bpat |= int'(busy) << c;
      if (c == 3) begin
        got = int'(out_data);
        waddr = int'(ram_wraddress);
      end
    end
    chk("out_valid timing", vpat, 8);
    chk("busy window", bpat, 15);
    repeat (2) @(negedge clock);
  endtask

  initial begin
    int got, waddr, w0, prev, a;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; enable = 1'b0; delay = '0; gain = '0;
    in_valid4 = 1'b0; in_data4 = '0; enable4 = 1'b1; delay4 = 4'd15; gain4 = 4'd8;

    #2;
    chk("reset strobes", int'({out_valid, busy, overrun, ram_wren, ram_rden}), 0);
    chk("reset data", int'(out_data) | int'(ram_data) | int'(ram_wraddress) | int'(ram_rdaddress), 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Warm-up over 0x7FFF-filled RAM, delay 10, gain 15
    for (int i = 0; i < 10; i++) add(100, 1'b1, 10, 15, 100, i == 0);
    add(100, 1'b1, 10, 15, 193, 1'b0);
    // Impulse, delay 4, gain 8
    add(1000, 1'b1, 4, 8, 1000, 1'b1);
    for (int i = 1; i <= 12; i++)
      add(0, 1'b1, 4, 8, (i == 4) ? 500 : (i == 8) ? 250 : (i == 12) ? 125 : 0, 1'b0);
    // Saturation both ways
    add(30000, 1'b1, 1, 15, 30000, 1'b1);
    add(30000, 1'b1, 1, 15, 32767, 1'b0);
    add(-30000, 1'b1, 1, 15, -30000, 1'b1);
    add(-30000, 1'b1, 1, 15, -32768, 1'b0);
    // Dry pass-through, then echo of the dry sample
    add(5000, 1'b1, 1, 15, 5000, 1'b1);
    add(4000, 1'b0, 1, 15, 4000, 1'b0);
    add(0, 1'b1, 1, 15, 3750, 1'b0);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      do_sample(tbl[i].din, tbl[i].en, tbl[i].dly, tbl[i].g, got, waddr);
      chk($sformatf("vec%0d out_data", i), got, tbl[i].exp);
    end

    // in_valid held two clocks: second strobe dropped
    do_reset();
    w0 = wren_cnt;
    @(negedge clock);
    in_data = 16'sd111; enable = 1'b1; delay = 11'd2; gain = 4'd8; in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_data = 16'sd222;
    chk("overrun before drop", int'(overrun), 0);
    @(negedge clock);
    in_valid = 1'b0;
    chk("overrun pulse", int'(overrun), 1);
    @(negedge clock);
    chk("overrun cleared", int'(overrun), 0);
    @(negedge clock);
    chk("overrun sample valid", int'(out_valid), 1);
    chk("overrun sample data", int'(out_data), 111);
    chk("overrun sample waddr", int'(ram_wraddress), 0);
    repeat (4) @(negedge clock);
    chk("single write", wren_cnt - w0, 1);
    do_sample(333, 1'b1, 2, 8, got, waddr);
    chk("post-overrun waddr", waddr, 1);
    chk("post-overrun data", got, 333);

    // Reset during WR aborts the write
    do_reset();
    do_sample(50, 1'b1, 2, 8, got, waddr);
    chk("pre-abort data", got, 50);
    @(negedge clock);
    in_data = 16'sd60; enable = 1'b1; delay = 11'd2; gain = 4'd8; in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    repeat (3) @(negedge clock);
    chk("abort out_valid before", int'(out_valid), 1);
    a = int'(ram_wraddress);
    chk("abort waddr", a, 1);
    prev = int'(mem[a]);
    #1 reset = 1'b1;
    #1;
    chk("abort out_valid drop", int'(out_valid), 0);
    chk("abort wren drop", int'(ram_wren), 0);
    @(negedge clock);
    reset = 1'b0;
    chk("abort no write", int'(mem[a]), prev);
    do_sample(777, 1'b1, 2, 15, got, waddr);
    chk("after abort data", got, 777);
    chk("after abort waddr", waddr, 0);

    // 16-deep line, delay 15: impulse after the pointer has wrapped
    do_reset();
    for (int s = 0; s <= 35; s++) begin
      @(negedge clock);
      in_data4 = (s == 20) ? 16'sd800 : 16'sd0;
      in_valid4 = 1'b1;
      @(posedge clock);
      @(negedge clock);
      in_valid4 = 1'b0;
      repeat (3) @(negedge clock);
      if (s >= 20)
        chk($sformatf("wrap s%0d", s), out_valid4 ? int'(out_data4) : -99999,
            (s == 20) ? 800 : (s == 35) ? 400 : 0);
      repeat (3) @(negedge clock);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
